// File: rtl/isa_pkg.sv
// Shared 9-bit instruction format: mnemonic encodings and field widths used by
// both the loader (encoder side) and the CTRL decoder.
package isa_pkg;

  localparam int OPC_W   = 3;
  localparam int OPND_W  = 6;
  localparam int INSTR_W = OPC_W + OPND_W;

  typedef enum logic [OPC_W-1:0] {
    MN_ADD = 3'b000,
    MN_SUB = 3'b001,
    MN_LDR = 3'b100,
    MN_STR = 3'b101,
    MN_BRZ = 3'b111
  } mnemonic_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } load_state_t;

  // 010, 011 and 110 are unassigned opcodes.
  function automatic logic is_legal(input logic [OPC_W-1:0] mnem);
    case (mnem)
      MN_ADD, MN_SUB, MN_LDR, MN_STR, MN_BRZ: is_legal = 1'b1;
      default:                                is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small registered FIFO with a synchronous flush; no read-before-write bypass,
// so a pushed entry becomes visible at the head one cycle later.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count == (PTR_W+1)'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs {mnemonic, operand} into 9-bit words and streams them through a small
// FIFO into instruction memory at consecutive addresses starting at base_addr.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPC_W-1:0]   in_mnem,
  input  logic [OPND_W-1:0]  in_operand,
  input  logic               in_last,
  output logic               imem_we,
  input  logic               imem_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err_illegal,
  output logic               err_ovf,
  output logic [ADDR_W:0]    word_count
);

  localparam int FW = INSTR_W + 2;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  load_state_t        state;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W:0]    count;
  logic               ill_q, ovf_q;

  logic               fifo_full, fifo_empty;
  logic [FW-1:0]      head, entry;
  logic               active, legal, accept, push, pop, write_ok, overflow;

  // Entry layout {wdata, last, nowrite}; a nowrite entry only carries the last flag.
  always_comb begin
    active     = (state == ST_LOAD) || (state == ST_DRAIN);
    legal      = is_legal(in_mnem);
    in_ready   = !fifo_full && (state == ST_LOAD) && !ovf_q;
    accept     = in_valid && in_ready;
    push       = accept && (legal || in_last);
    entry      = {in_mnem, in_operand, in_last, !legal};
    imem_we    = active && !fifo_empty && !head[0];
    write_ok   = imem_we && imem_ready;
    pop        = active && !fifo_empty && (head[0] || imem_ready);
    overflow   = write_ok && (addr == ADDR_MAX) && !head[1];
    imem_wdata = imem_we ? head[FW-1:2] : '0;
    imem_addr  = addr;
    busy       = active;
    done       = (state == ST_DONE);
    err_illegal = ill_q;
    err_ovf    = ovf_q;
    word_count = count;
  end

  sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (overflow),
    .push  (push),
    .pop   (pop),
    .wdata (entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Address saturates at the top of imem; an overflowing write ends the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      addr  <= '0;
      count <= '0;
      ill_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept && !legal) ill_q <= 1'b1;
      if (write_ok) begin
        count <= count + (ADDR_W+1)'(1);
        if (addr != ADDR_MAX) addr <= addr + ADDR_W'(1);
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_LOAD;
            addr  <= base_addr;
            count <= '0;
            ill_q <= 1'b0;
            ovf_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (overflow) begin
            ovf_q <= 1'b1;
            state <= ST_DONE;
          end else if (accept && in_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (overflow) begin
            ovf_q <= 1'b1;
            state <= ST_DONE;
          end else if (fifo_empty) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed and randomized programs checked
// against a list-based model of which words should land at which addresses.
module tb_instr_encoder_loader;
  import isa_pkg::*;

  typedef struct {
    logic [2:0] m;
    logic [5:0] o;
    logic       l;
  } item_t;

  typedef struct {
    int a;
    int d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel4 = 1'b0;
  logic       start_r = 1'b0;
  logic       valid_r = 1'b0;
  logic       in_last = 1'b0;
  logic       imem_ready = 1'b0;
  logic [7:0] base = 8'h00;
  logic [2:0] in_mnem = 3'b000;
  logic [5:0] in_operand = 6'h00;

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;
  int wait_cnt = 0;
  int first_block = -1;
  logic saw_block = 1'b0;

  item_t prog[$];
  wr_t   got[$];
  wr_t   exp_q[$];
  logic  exp_ill, exp_ovf;

  wire       rdy8, we8, busy8, done8, ill8, ovf8;
  wire [7:0] addr8;
  wire [8:0] wdata8, wc8;
  wire       rdy4, we4, busy4, done4, ill4, ovf4;
  wire [3:0] addr4;
  wire [8:0] wdata4;
  wire [4:0] wc4;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_r && !sel4), .base_addr(base),
    .in_valid(valid_r && !sel4), .in_ready(rdy8), .in_mnem(in_mnem),
    .in_operand(in_operand), .in_last(in_last), .imem_we(we8),
    .imem_ready(imem_ready), .imem_addr(addr8), .imem_wdata(wdata8),
    .busy(busy8), .done(done8), .err_illegal(ill8), .err_ovf(ovf8),
    .word_count(wc8)
  );

  instr_encoder_loader #(.ADDR_W(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_r && sel4), .base_addr(base[3:0]),
    .in_valid(valid_r && sel4), .in_ready(rdy4), .in_mnem(in_mnem),
    .in_operand(in_operand), .in_last(in_last), .imem_we(we4),
    .imem_ready(imem_ready), .imem_addr(addr4), .imem_wdata(wdata4),
    .busy(busy4), .done(done4), .err_illegal(ill4), .err_ovf(ovf4),
    .word_count(wc4)
  );

  wire       rdy   = sel4 ? rdy4 : rdy8;
  wire       we    = sel4 ? we4 : we8;
  wire [7:0] addr  = sel4 ? {4'h0, addr4} : addr8;
  wire [8:0] wdata = sel4 ? wdata4 : wdata8;
  wire       busy  = sel4 ? busy4 : busy8;
  wire       done  = sel4 ? done4 : done8;
  wire       ill   = sel4 ? ill4 : ill8;
  wire       ovf   = sel4 ? ovf4 : ovf8;
  wire [8:0] wc    = sel4 ? {4'h0, wc4} : wc8;

  task automatic checkOutput(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  // imem model: mode 0 always ready, 1 holds off 3 cycles per write, 2 random, 3 never.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: imem_ready = 1'b1;
      1: begin
        if (we && !imem_ready) begin
          wait_cnt++;
          if (wait_cnt >= 4) imem_ready = 1'b1;
        end else begin
          wait_cnt = 0;
          imem_ready = 1'b0;
        end
      end
      2: imem_ready = 1'($urandom_range(0, 1));
      default: imem_ready = 1'b0;
    endcase
  end

  // Collect accepted writes and check that a stalled write holds its address and data.
  logic prev_stall = 1'b0;
  int   prev_a = 0, prev_d = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_we", 32'(we), 32'd1);
        checkOutput("hold_addr", 32'(addr), prev_a);
        checkOutput("hold_wdata", 32'(wdata), prev_d);
      end
      if (we && imem_ready) begin
        wr_t w;
        w.a = int'(addr);
        w.d = int'(wdata);
        got.push_back(w);
      end
      prev_stall = we && !imem_ready;
      prev_a = int'(addr);
      prev_d = int'(wdata);
    end
  end

  // Reference: legal words go to base, base+1, ... until imem runs out of addresses.
  task automatic buildExpected(input logic s4, input logic [7:0] b);
    int a, maxa;
    wr_t w;
    a = int'(b);
    maxa = s4 ? 15 : 255;
    exp_q.delete();
    exp_ill = 1'b0;
    exp_ovf = 1'b0;
    foreach (prog[i]) begin
      if (!(prog[i].m inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd7})) begin
        exp_ill = 1'b1;
      end else if (a > maxa) begin
        exp_ovf = 1'b1;
        break;
      end else begin
        w.a = a;
        w.d = int'({prog[i].m, prog[i].o});
        exp_q.push_back(w);
        a++;
      end
    end
  endtask

  task automatic applyStimulus(input logic s4, input logic [7:0] b, input int gap_max,
                               input logic spur, input logic finish);
    int   lim;
    logic aborted;
    logic first_legal;
    sel4 = s4;
    base = b;
    got.delete();
    saw_block = 1'b0;
    first_block = -1;
    aborted = 1'b0;
    first_legal = (prog.size() > 0) && (prog[0].m inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd7});
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    foreach (prog[i]) begin
      if (aborted) break;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      in_mnem = prog[i].m;
      in_operand = prog[i].o;
      in_last = prog[i].l;
      valid_r = 1'b1;
      lim = 0;
      forever begin
        @(negedge clk);
        if (i == 1 && lim == 0 && first_legal && gap_max == 0)
          checkOutput("latency_we", 32'(we), 32'd1);
        if (rdy) begin
          if (i == 0 && first_legal) checkOutput("no_bypass", 32'(we), 32'd0);
          break;
        end
        if (!saw_block) first_block = i;
        saw_block = 1'b1;
        if (done) begin
          aborted = 1'b1;
          break;
        end
        if (++lim > 300) begin
          checkOutput("accept_timeout", 32'd0, 32'd1);
          aborted = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
      valid_r = 1'b0;
      if (spur && prog.size() > 1 && i == prog.size() / 2) begin
        start_r = 1'b1;
        base = ~b;
        @(posedge clk); #1;
        start_r = 1'b0;
        base = b;
      end
    end
    if (finish) begin
      lim = 0;
      do begin @(negedge clk); lim++; end while (!done && lim < 2000);
      checkOutput("done", 32'(done), 32'd1);
      buildExpected(s4, b);
      checkOutput("n_writes", got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
        checkOutput($sformatf("wr%0d_addr", k), got[k].a, exp_q[k].a);
        checkOutput($sformatf("wr%0d_data", k), got[k].d, exp_q[k].d);
      end
      checkOutput("word_count", 32'(wc), exp_q.size());
      checkOutput("err_illegal", 32'(ill), 32'(exp_ill));
      checkOutput("err_ovf", 32'(ovf), 32'(exp_ovf));
      checkOutput("busy_at_done", 32'(busy), 32'd0);
      checkOutput("in_ready_at_done", 32'(rdy), 32'd0);
    end
  endtask

  task automatic addItem(input logic [2:0] m, input logic [5:0] o, input logic l);
    item_t it;
    it.m = m;
    it.o = o;
    it.l = l;
    prog.push_back(it);
  endtask

  task automatic specProgram();
    prog.delete();
    addItem(3'b000, 6'h05, 1'b0);
    addItem(3'b001, 6'h12, 1'b0);
    addItem(3'b100, 6'h3F, 1'b0);
    addItem(3'b101, 6'h00, 1'b0);
    addItem(3'b111, 6'h2A, 1'b1);
  endtask

  // Random program whose final (last-flagged) word is always a legal one.
  task automatic randomProgram(input int len);
    logic [2:0] legal_set [5] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd7};
    prog.delete();
    for (int i = 0; i < len - 1; i++)
      addItem(3'($urandom_range(0, 7)), 6'($urandom), 1'b0);
    addItem(legal_set[$urandom_range(0, 4)], 6'($urandom), 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_we", 32'(we8), 32'd0);
    checkOutput("reset_busy", 32'(busy8), 32'd0);
    checkOutput("reset_done", 32'(done8), 32'd0);
    checkOutput("reset_in_ready", 32'(rdy8), 32'd0);
    checkOutput("reset_addr", 32'(addr8), 32'd0);
    checkOutput("reset_count", 32'(wc8), 32'd0);
    checkOutput("reset_errs", 32'({ill8, ovf8}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Spec program with free-flowing imem.
    specProgram();
    rdy_mode = 0;
    applyStimulus(1'b0, 8'h10, 0, 1'b0, 1'b1);
    checkOutput("spec_word4", got.size() > 4 ? got[4].d : -1, 32'h1EA);

    // Same program with imem stalling every write.
    rdy_mode = 1;
    applyStimulus(1'b0, 8'h10, 0, 1'b0, 1'b1);
    checkOutput("backpressure_seen", 32'(saw_block), 32'd1);
    checkOutput("accepted_before_block", first_block, 32'd4);

    // Illegal mnemonic in the middle is dropped without a hole in the addresses.
    prog.delete();
    addItem(3'b000, 6'h05, 1'b0);
    addItem(3'b110, 6'h01, 1'b0);
    addItem(3'b111, 6'h2A, 1'b1);
    rdy_mode = 0;
    applyStimulus(1'b0, 8'h20, 0, 1'b0, 1'b1);

    // Illegal last word still terminates the load.
    prog.delete();
    addItem(3'b001, 6'h11, 1'b0);
    addItem(3'b011, 6'h22, 1'b1);
    applyStimulus(1'b0, 8'h28, 0, 1'b0, 1'b1);

    // Overflow on the 16-word instance: base 0xE, four words.
    prog.delete();
    addItem(3'b000, 6'h01, 1'b0);
    addItem(3'b001, 6'h02, 1'b0);
    addItem(3'b100, 6'h03, 1'b0);
    addItem(3'b111, 6'h04, 1'b1);
    applyStimulus(1'b1, 8'h0E, 0, 1'b0, 1'b1);
    checkOutput("ovf_done", 32'(done4), 32'd1);
    sel4 = 1'b0;

    // Start pulse mid-load must not move the base or clear the count.
    randomProgram(6);
    applyStimulus(1'b0, 8'h30, 0, 1'b1, 1'b1);

    // Reset while two words are queued in DRAIN.
    prog.delete();
    addItem(3'b100, 6'h0A, 1'b0);
    addItem(3'b101, 6'h0B, 1'b1);
    rdy_mode = 3;
    applyStimulus(1'b0, 8'h50, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("drain_busy", 32'(busy8), 32'd1);
    checkOutput("drain_we", 32'(we8), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_we", 32'(we8), 32'd0);
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_addr", 32'(addr8), 32'd0);
    checkOutput("rst_wdata", 32'(wdata8), 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (4) @(negedge clk);
    checkOutput("no_write_after_reset", got.size(), 32'd0);
    checkOutput("idle_after_reset", 32'({we8, busy8, done8}), 32'd0);
    specProgram();
    applyStimulus(1'b0, 8'h70, 0, 1'b0, 1'b1);

    // Randomized programs, ready patterns and input gaps.
    for (int t = 0; t < 12; t++) begin
      randomProgram($urandom_range(1, 10));
      rdy_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      applyStimulus(1'b0, 8'($urandom_range(0, 200)), 2, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
